two_bit_counter: RTL and testbench



---
 rtl/two_bit_counter.sv | 45 ++++
 tb/tb_two_bit_counter.sv | 99 +++++++++
 2 files changed

// File: rtl/two_bit_counter.sv
// two_bit_counter: 2-bit hold/up/down/Gray counter with enable and one-cycle wrap strobe
// Ports: clock (rising edge), Reset (async, active-low), En (count enable),
//        select (00 hold, 01 up, 10 down, 11 Gray), Counter_Out (registered count),
//        out1 (registered wrap strobe).
// Build option: define TWO_BIT_COUNTER_SAT_EN to saturate at the terminal value
// instead of wrapping; out1 then stays high while the counter sits saturated.
module two_bit_counter #(
  parameter logic [1:0] RESET_VALUE = 2'b00
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       En,
  input  logic [1:0] select,
  output logic [1:0] Counter_Out,
  output logic       out1
);
  logic [1:0] cnt_q, cnt_d, nxt;
  logic       wrap_q, wrap_d, term;
  always_comb begin
    // Gray step 00->01->11->10->00 is {b0, ~b1}
    nxt = select == 2'b01 ? cnt_q + 2'd1 :
          select == 2'b10 ? cnt_q - 2'd1 :
          select == 2'b11 ? {cnt_q[0], ~cnt_q[1]} : cnt_q;
    term = select == 2'b01 ? cnt_q == 2'b11 :
           select == 2'b10 ? cnt_q == 2'b00 :
           select == 2'b11 ? cnt_q == 2'b10 : 1'b0;
`ifdef TWO_BIT_COUNTER_SAT_EN
    cnt_d = En && !term ? nxt : cnt_q;
`else
    cnt_d = En ? nxt : cnt_q;
`endif
    wrap_d = En && term;
  end
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q  <= RESET_VALUE;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
  assign Counter_Out = cnt_q;
  assign out1        = wrap_q;
endmodule

// File: tb/tb_two_bit_counter.sv
// tb_two_bit_counter: scoreboard bench for two_bit_counter (wrap or saturating build)
module tb_two_bit_counter;
  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       En = 1'b1;
  logic [1:0] select = 2'b01;
  logic [1:0] Counter_Out;
  logic       out1;
  int         passed = 0;
  int         total = 0;
  logic [1:0] m_cnt = 2'b00;
  logic [2:0] exp_q[$];
`ifdef TWO_BIT_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  two_bit_counter dut (
    .clock(clock), .Reset(Reset), .En(En), .select(select),
    .Counter_Out(Counter_Out), .out1(out1)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  // returns {flag, next count}
  function automatic logic [2:0] model(input logic [1:0] c, input logic en, input logic [1:0] sel);
    int gt[4] = '{1, 3, 0, 2};
    int v = int'(c);
    int nv;
    bit t;
    if (!en || sel == 2'b00) return {1'b0, c};
    case (sel)
      2'b01:   begin t = (v == 3); nv = (v + 1) % 4; end
      2'b10:   begin t = (v == 0); nv = (v + 3) % 4; end
      default: begin t = (v == 2); nv = gt[v]; end
    endcase
    if (SAT && t) nv = v;
    return {t, 2'(nv)};
  endfunction
  task automatic step(input logic en, input logic [1:0] sel, input string tag);
    logic [2:0] e;
    En = en;
    select = sel;
    e = model(m_cnt, en, sel);
    exp_q.push_back(e);
    m_cnt = e[1:0];
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk({tag, " cnt"}, Counter_Out, e[1:0]);
    chk({tag, " out1"}, {1'b0, out1}, {1'b0, e[2]});
  endtask
  // reset asserted between edges must clear outputs without a clock edge
  task automatic rst_pulse(input string tag);
    @(posedge clock);
    #3;
    Reset = 1'b0;
    #1;
    chk({tag, " rst cnt"}, Counter_Out, 2'b00);
    chk({tag, " rst out1"}, {1'b0, out1}, 2'b00);
    #1;
    Reset = 1'b1;
    m_cnt = 2'b00;
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("in_reset cnt", Counter_Out, 2'b00);
      chk("in_reset out1", {1'b0, out1}, 2'b00);
    end
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 2'b10, "down");
    rst_pulse("pre_gray");
    for (int i = 0; i < 5; i++) step(1'b1, 2'b11, "gray");
    rst_pulse("pre_up");
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, "up");
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, "en_off");
    rst_pulse("pre_hold");
    step(1'b1, 2'b01, "to_one");
    step(1'b1, 2'b01, "to_two");
    chk("at_two", Counter_Out, 2'b10);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b00, "hold");
    step(1'b1, 2'b01, "no_reload");
    chk("no_reload val", Counter_Out, 2'b11);
    step(1'b1, 2'b01, "wrap_up");
    chk("strobe before rst", {1'b0, out1}, 2'b01);
    rst_pulse("mid_strobe");
    for (int i = 0; i < 6; i++) step(1'b1, 2'b01, "sat_up");
    step(1'b1, 2'b10, "leave_up");
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), "rand");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
